// File: rtl/johnson_seq_ctrl_if.sv
// Host <-> johnson_seq_ctrl handshake and status bundle.
interface johnson_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic               start;
  logic [CNT_W-1:0]   num_rev;
  logic               hold;
  logic               abort;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   jc;
  logic [2*WIDTH-1:0] phase;
  logic [CNT_W-1:0]   rev_cnt;
  logic               err;

  // Host side: issues run control, observes progress.
  modport master (
    output start, num_rev, hold, abort,
    input  busy, done, jc, phase, rev_cnt, err
  );

  // Controller side.
  modport slave (
    input  start, num_rev, hold, abort,
    output busy, done, jc, phase, rev_cnt, err
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter run controller: steps a WIDTH-bit Johnson register for a
// programmed number of revolutions with hold/abort, one-hot phase decode.
// Optional macro JOHNSON_SELFCHK_EN adds an illegal-code recovery checker
// driving the sticky err flag; without it err is tied low.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  johnson_seq_ctrl_if.slave   bus
);
  localparam int PH = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] jc_q, jc_d;
  logic [CNT_W-1:0] rev_q, rev_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [PH-1:0]    phase;

  // Code reached after k steps from all-zero.
  function automatic logic [WIDTH-1:0] code_at(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < k; i++) c = {~c[0], c[WIDTH-1:1]};
    return c;
  endfunction

`ifdef JOHNSON_SELFCHK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] trans;
  logic             legal;

  // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    trans = (jc_q ^ (jc_q >> 1)) & {1'b0, {(WIDTH-1){1'b1}}};
    legal = ((trans & (trans - 1'b1)) == '0);
  end
`endif

  // State register and run bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      jc_q    <= '0;
      rev_q   <= '0;
      tgt_q   <= '0;
`ifdef JOHNSON_SELFCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      jc_q    <= jc_d;
      rev_q   <= rev_d;
      tgt_q   <= tgt_d;
`ifdef JOHNSON_SELFCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: abort beats hold beats step; start only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    jc_d    = jc_q;
    rev_d   = rev_q;
    tgt_d   = tgt_q;
`ifdef JOHNSON_SELFCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          tgt_d   = bus.num_rev;
          rev_d   = '0;
          jc_d    = '0;
`ifdef JOHNSON_SELFCHK_EN
          err_d   = 1'b0;
`endif
          state_d = (bus.num_rev == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          jc_d    = '0;
        end
`ifdef JOHNSON_SELFCHK_EN
        else if (!legal) begin
          jc_d  = '0;
          err_d = 1'b1;
        end
`endif
        else if (!bus.hold) begin
          jc_d = {~jc_q[0], jc_q[WIDTH-1:1]};
          // Last code of a revolution wraps back to zero.
          if (jc_q == WIDTH'(1)) begin
            rev_d = rev_q + 1'b1;
            if ((rev_q + 1'b1) == tgt_q) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-hot phase decode, gated to RUN.
  for (genvar k = 0; k < PH; k++) begin : g_phase
    assign phase[k] = (state_q == RUN) && (jc_q == code_at(k));
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.jc      = jc_q;
  assign bus.phase   = phase;
  assign bus.rev_cnt = rev_q;
`ifdef JOHNSON_SELFCHK_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios then random traffic,
// checked every cycle against a phase-index reference model.
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int P  = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  johnson_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, busy_cnt = 0, done_cnt = 0;
  // model: mode 0=idle 1=run 2=done; idx = steps taken in current revolution
  int   m_mode = 0, m_idx = 0, m_rev = 0, m_tgt = 0;
  logic m_err = 1'b0;

  // Johnson code after k steps: k ones from the top, then ones draining out.
  function automatic logic [W-1:0] code(input int k);
    logic [31:0] v;
    if (k <= W) v = ((32'd1 << k) - 1) << (W - k);
    else        v = (32'd1 << (2 * W - k)) - 1;
    return v[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input logic s, input int n, input logic h, input logic a,
                     input logic r = 1'b1, input logic inj = 1'b0);
    logic [P-1:0] exp_ph;
    @(negedge clk);
    bus.start = s; bus.num_rev = CW'(n); bus.hold = h; bus.abort = a; rst_n = r;
`ifdef JOHNSON_SELFCHK_EN
    if (inj) begin
      force dut.jc_q = 4'b1010;
      #1 release dut.jc_q;
    end
`endif
    @(posedge clk);
    if (!r) begin
      m_mode = 0; m_idx = 0; m_rev = 0; m_tgt = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: if (s && !a) begin
             m_tgt = n; m_rev = 0; m_idx = 0; m_err = 1'b0;
             m_mode = (n == 0) ? 2 : 1;
           end
        1: if (a) begin
             m_mode = 0; m_idx = 0;
           end else if (inj) begin
             m_idx = 0; m_err = 1'b1;
           end else if (!h) begin
             m_idx++;
             if (m_idx == P) begin
               m_idx = 0; m_rev++;
               if (m_rev == m_tgt) m_mode = 2;
             end
           end
        default: m_mode = 0;
      endcase
    end
    #1;
    exp_ph = (m_mode == 1) ? (P'(1) << m_idx) : '0;
    chk("busy",    32'(bus.busy),    32'(m_mode == 1));
    chk("done",    32'(bus.done),    32'(m_mode == 2));
    chk("jc",      32'(bus.jc),      32'(code(m_idx)));
    chk("phase",   32'(bus.phase),   32'(exp_ph));
    chk("rev_cnt", 32'(bus.rev_cnt), 32'(m_rev));
    chk("err",     32'(bus.err),     32'(m_err));
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  initial begin
    bus.start = 1'b0; bus.num_rev = '0; bus.hold = 1'b0; bus.abort = 1'b0;

    // reset, then reset in the middle of a 3-revolution run
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // two revolutions, no hold: start accepted right after reset
    busy_cnt = 0; done_cnt = 0;
    cyc(1, 2, 0, 0);
    repeat (17) cyc(0, 0, 0, 0);
    chk("run2_busy_cycles", busy_cnt, 16);
    chk("run2_done_pulses", done_cnt, 1);
    chk("run2_rev_readback", 32'(bus.rev_cnt), 2);

    // zero revolutions
    busy_cnt = 0; done_cnt = 0;
    cyc(1, 0, 0, 0);
    chk("rev0_done", 32'(bus.done), 1);
    cyc(0, 0, 0, 0);
    chk("rev0_busy_cycles", busy_cnt, 0);
    chk("rev0_done_pulses", done_cnt, 1);

    // start during RUN is ignored
    done_cnt = 0;
    cyc(1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 5, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    chk("ignore_start_done", done_cnt, 1);
    cyc(0, 0, 0, 0);

    // hold three cycles at 1110
    busy_cnt = 0; done_cnt = 0;
    cyc(1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    chk("hold_jc", 32'(bus.jc), 32'h0e);
    repeat (6) cyc(0, 0, 0, 0);
    chk("hold_busy_cycles", busy_cnt, 11);
    chk("hold_done_pulses", done_cnt, 1);

    // abort at 0011 during second revolution
    done_cnt = 0;
    cyc(1, 5, 0, 0);
    repeat (14) cyc(0, 0, 0, 0);
    chk("pre_abort_jc", 32'(bus.jc), 32'h03);
    cyc(0, 0, 0, 1);
    chk("abort_rev", 32'(bus.rev_cnt), 1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("abort_no_done", done_cnt, 0);
    cyc(1, 3, 0, 1);
    chk("abort_start_idle", 32'(bus.busy), 0);
    cyc(0, 0, 0, 0);

`ifdef JOHNSON_SELFCHK_EN
    // illegal code recovery, overriding hold; err clears on next start
    cyc(1, 2, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1'b1, 1'b1);
    chk("selfchk_err", 32'(bus.err), 1);
    repeat (20) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("selfchk_err_clear", 32'(bus.err), 0);
    repeat (9) cyc(0, 0, 0, 0);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) == 0, $urandom_range(0, 3), ($urandom % 5) == 0,
          ($urandom % 23) == 0, ($urandom % 97) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Run controller for a Johnson-counter phase generator. Accepts a start request with a programmed revolution count and steps an internal WIDTH-bit Johnson register through its 2·WIDTH states, supporting hold and abort. It reports progress and a one-cycle completion pulse, and drives a one-hot phase bus for downstream multi-phase enable logic. It sits between a host/sequencer and the phase-consuming datapath.

## Interface
- WIDTH, 4, Johnson register width; gives 2·WIDTH phases per revolution; WIDTH ≥ 2
- CNT_W, 8, width of revolution count and progress counter
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  run request; accepted only in IDLE
- num_rev  input  CNT_W  revolutions to run; sampled on start acceptance
- hold  input  1  freezes stepping while in RUN
- abort  input  1  terminates any run and returns to IDLE
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- jc  output  WIDTH  Johnson register
- phase  output  2·WIDTH  one-hot phase decode; all-zero outside RUN
- rev_cnt  output  CNT_W  completed revolutions of current/last run
- err  output  1  sticky illegal-state flag; tied 0 without the macro

## Operation
- Reset (rst_n=0 at an edge): state IDLE, jc=0, rev_cnt=0, busy=0, done=0, phase=0, err=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0: latch target=num_rev, rev_cnt←0, jc←0, err←0.
  - Then go to RUN, or to DONE if num_rev=0.
  - start ignored in all other states.
- RUN, per edge:
  - abort=1: go to IDLE, jc←0.
  - Else hold=1: nothing changes.
  - Else step jc←{~jc[0], jc[WIDTH-1:1]}. WIDTH=4 sequence: 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Revolution completes on the step from {0…01} to 0: rev_cnt←rev_cnt+1. If the new value equals target, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - abort in DONE: go to IDLE; the done pulse for that cycle still shows.
- phase[k]=1 when busy and jc equals the code reached after k steps from 0 (k=0..2·WIDTH-1).
- rev_cnt and jc hold their values in IDLE after done or abort, for readback, until the next accepted start.
- Priority: rst_n > abort > hold > step.
- rev_cnt never wraps within a run, since target ≤ 2^CNT_W−1.

## Timing
- Start accepted at edge E0: busy=1, jc=0, phase[0]=1 from E0.
- With no hold, each edge advances one phase. The final revolution ends at edge E0+2·WIDTH·num_rev, which enters DONE: busy=0, done=1 for that cycle. IDLE follows at the next edge.
- busy high for exactly 2·WIDTH·num_rev cycles, plus one per held cycle.
- num_rev=0: DONE at E0 (busy never rises), done for one cycle.
- New start is accepted earliest in the cycle after DONE, i.e. back-to-back runs have a 1-cycle IDLE gap.
- Abort at edge Ea: busy=0, phase=0, jc=0 from Ea; no done pulse.
- All outputs registered, or decoded from registers only; no combinational input-to-output path.

## Configuration
- JOHNSON_SELFCHK_EN defined:
  - In RUN, if jc is not a legal Johnson code (neither 1…10…0 nor 0…01…1 form), the next non-aborted edge forces jc←0 and sets err←1. This overrides hold.
  - rev_cnt is unchanged on recovery.
  - err is sticky until reset or the next accepted start.
- Macro not defined: no checker logic, err tied to 0, and illegal codes keep shifting.

## Test plan
- Reset mid-run (WIDTH=4, num_rev=3, rst_n=0 at cycle 5) → next edge: all outputs 0, state IDLE; start at next cycle is accepted.
- WIDTH=4, start with num_rev=2, no hold → busy high 16 cycles, jc follows the 8-code sequence twice, phase one-hot tracks it, rev_cnt 0→1→2, done single pulse, rev_cnt reads 2 afterwards.
- num_rev=0 → done pulses the cycle after the start edge, busy stays 0, jc=0; start during RUN of another run is ignored (rev_cnt target unchanged).
- num_rev=1, hold high 3 cycles at jc=1110 → jc frozen at 1110, busy stretches to 11 cycles, done still single.
- num_rev=5, abort at jc=0011 during 2nd revolution → busy=0, jc=0, phase=0, no done, rev_cnt holds 1; abort+start same cycle in IDLE → stays IDLE.
- With JOHNSON_SELFCHK_EN, force jc=1010 in RUN → next edge jc=0000, err=1, run continues; err clears on next start. Without the macro, err stays 0.
